serial_add_sub: RTL and testbench

Multi-cycle add/subtract unit. It is the parametrised successor of the single-bit full adder in the ALU datapath. Operands are latched on a start pulse, then processed DIGIT bits per clock through a DIGIT-bit ripple slice, so area is traded for latency. The result and flags (carry, signed overflow, zero) are presented with a one-cycle done pulse to the ALU controller.

---
 rtl/serial_add_sub.sv | 113 +++++++++++
 tb/tb_serial_add_sub.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial add/subtract unit; DIGIT bits per clock.
// Produces the result with carry, signed-overflow and zero flags and a one-cycle done pulse.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d, s_ext;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d, done_q, done_d;
  logic [DIGIT:0] slice;
  logic last;
  assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
  assign s_ext = WIDTH'(slice[DIGIT-1:0]);
  assign last = (state_q == RUN) && (cnt_q == CW'(N - 1));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    sum_d = sum_q;
    c_out_d = c_out_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d = a;
        b_d = mode ? ~b : b;
        carry_d = mode ^ c_in;
        amsb_d = a[WIDTH-1];
        bmsb_d = mode ? ~b[WIDTH-1] : b[WIDTH-1];
        res_d = '0;
        cnt_d = '0;
        state_d = RUN;
      end
    end else begin
      // new digit enters at the MSB so the first digit lands at bit 0 after N steps
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      res_d = (res_q >> DIGIT) | (s_ext << (WIDTH - DIGIT));
      carry_d = slice[DIGIT];
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sum_d = res_d;
        c_out_d = slice[DIGIT];
        ovf_d = (amsb_q == bmsb_q) && (res_d[WIDTH-1] != amsb_q);
        zero_d = ~|res_d;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      sum_q <= '0;
      c_out_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      sum_q <= sum_d;
      c_out_q <= c_out_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum = sum_q;
  assign c_out = c_out_q;
  assign overflow = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of the 8/1 and 16/4 configurations.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0, c_in = 1'b0, st8 = 1'b0, st16 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy8, done8, c8, o8, z8, busy16, done16, c16, o16, z16;
  logic [7:0] sum8;
  logic [15:0] sum16;
  int n_chk = 0, n_bad = 0;
  int sa, sb, r, ua, ub, ndone, unstable;
  logic [15:0] x, y;
  bit m, ci;
  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst), .start(st8), .mode(mode), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c8), .overflow(o8), .zero(z8));
  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .start(st16), .mode(mode), .a(a), .b(b), .c_in(c_in),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(c16), .overflow(o16), .zero(z16));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic op(input bit w, input bit md, input logic [15:0] xa, input logic [15:0] xb,
                    input bit ci_, input logic [15:0] es, input bit ec, input bit eo,
                    input bit ez, input string tag);
    int lat, nbusy;
    @(negedge clk);
    mode = md; a = xa; b = xb; c_in = ci_; st8 = !w; st16 = w;
    @(posedge clk);
    #1 st8 = 1'b0; st16 = 1'b0;
    lat = 0; nbusy = 0;
    while (!(w ? done16 : done8) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (w ? busy16 : busy8) nbusy++;
    end
    chk({tag, "_lat"}, lat, w ? 5 : 9);
    chk({tag, "_busy"}, nbusy, w ? 4 : 8);
    chk({tag, "_sum"}, w ? sum16 : {8'h0, sum8}, w ? es : {8'h0, es[7:0]});
    chk({tag, "_flags"}, w ? {c16, o16, z16} : {c8, o8, z8}, {ec, eo, ez});
    @(negedge clk);
    chk({tag, "_pulse"}, w ? done16 : done8, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_init", {busy8, done8, sum8, c8, o8, z8, busy16, done16, sum16, c16, o16, z16}, 0);
    rst = 1'b0;
    op(0, 0, 16'h7F, 16'h01, 0, 16'h80, 0, 1, 0, "add7f");
    op(0, 0, 16'hFF, 16'h00, 1, 16'h00, 1, 0, 1, "addc");
    op(0, 1, 16'h05, 16'h05, 0, 16'h00, 1, 0, 1, "sub_eq");
    op(0, 1, 16'h00, 16'h01, 0, 16'hFF, 0, 0, 0, "sub_neg");
    op(0, 1, 16'h80, 16'h01, 0, 16'h7F, 1, 1, 0, "sub_ovf");
    op(0, 1, 16'h10, 16'h03, 1, 16'h0C, 1, 0, 0, "sub_brw");
    // start held high; only the first and E0+9 operands may be used
    @(negedge clk);
    mode = 0; c_in = 0; a = 16'h11; b = 16'h22; st8 = 1'b1;
    ndone = 0; unstable = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (k == 9) chk("hold_first", sum8, 8'h33);
      if (k > 9 && k < 18 && sum8 != 8'h33) unstable++;
      if (k == 18) begin
        chk("hold_second", sum8, 8'h45);
        chk("hold_done18", done8, 1);
        st8 = 1'b0;
      end
      if (k == 9) begin
        a = 16'h40; b = 16'h05; mode = 0; c_in = 0;
      end else begin
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom); c_in = 1'($urandom);
      end
    end
    chk("hold_ndone", ndone, 2);
    chk("hold_stable", unstable, 0);
    @(negedge clk);
    chk("hold_idle", {busy8, done8}, 0);
    // asynchronous reset in the middle of an add
    @(negedge clk);
    mode = 0; c_in = 0; a = 16'h7F; b = 16'h01; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", {busy8, done8, sum8, c8, o8, z8}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    chk("rst_nodone", ndone, 0);
    op(0, 0, 16'h12, 16'h34, 0, 16'h46, 0, 0, 0, "add_post");
    op(1, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, "w16_wrap");
    op(1, 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1, 0, "w16_ovf");
    op(1, 0, 16'h1234, 16'h4321, 1, 16'h5556, 0, 0, 0, "w16_addc");
    op(1, 1, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0, 0, "w16_brw");
    for (int i = 0; i < 100; i++) begin
      x = 16'($urandom); y = 16'($urandom); m = 1'($urandom); ci = 1'($urandom);
      sa = $signed(x); sb = $signed(y); ua = x; ub = y;
      r = m ? sa - sb - int'(ci) : sa + sb + int'(ci);
      op(1, m, x, y, ci, r[15:0], m ? (ua >= ub + int'(ci)) : (ua + ub + int'(ci) > 65535),
         (r > 32767) || (r < -32768), r[15:0] == 16'h0, "rnd");
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
